// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for memory requests, branch redirects, halt drain and memory-timeout fault.
module fetch_ctrl #(
  parameter int unsigned ADDR    = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic            de_stall_i,
  input  logic            br_req_i,
  input  logic [ADDR-1:0] br_addr_i,
  input  logic [ADDR-1:0] fetch_addr_i,
  output logic            mem_req_o,
  output logic [ADDR-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  output logic            if_stall_o,
  output logic            if_branch_o,
  output logic [ADDR-1:0] if_baddr_o,
  output logic            flush_o,
  output logic            err_o,
  output logic [1:0]      state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t          r_state;
  logic            r_pb_v;
  logic [ADDR-1:0] r_pb_addr;
  logic [7:0]      r_wait;
  logic            r_err;
  logic            w_run;
  logic            w_busy;
  logic            w_adv;
  logic            w_redir;
  logic            w_to;
  always_comb begin
    w_run   = r_state == RUN;
    w_busy  = w_run | (r_state == DRAIN);
    w_adv   = w_run & mem_ack_i & ~de_stall_i & ~halt_i;
    w_redir = w_run & mem_ack_i & ~halt_i & (r_pb_v | br_req_i);
    w_to    = w_busy & ~mem_ack_i & (r_wait == TO_LAST);
  end
  assign mem_req_o   = w_busy;
  assign mem_addr_o  = fetch_addr_i;
  assign if_stall_o  = ~(w_adv | w_redir);
  assign if_branch_o = w_redir;
  assign flush_o     = w_redir;
  // a same-cycle branch is newer than anything pending, so it wins the redirect
  assign if_baddr_o  = w_redir ? (br_req_i ? br_addr_i : r_pb_addr) : '0;
  assign err_o       = r_err;
  assign state_o     = r_state;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pb_v    <= 1'b0;
      r_pb_addr <= '0;
      r_wait    <= 8'd0;
      r_err     <= 1'b0;
    end else begin
      r_wait <= (w_busy & ~mem_ack_i & ~w_to) ? r_wait + 8'd1 : 8'd0;
      if (w_to) begin
        r_state <= HALT;
        r_err   <= 1'b1;
        r_pb_v  <= 1'b0;
      end else begin
        case (r_state)
          IDLE:  r_state <= start_i ? RUN : IDLE;
          RUN: begin
            if (halt_i) begin
              r_pb_v  <= 1'b0;
              r_state <= mem_ack_i ? HALT : DRAIN;
            end else if (w_redir) begin
              r_pb_v <= 1'b0;
            end else if (br_req_i) begin
              r_pb_v    <= 1'b1;
              r_pb_addr <= br_addr_i;
            end
          end
          DRAIN: r_state <= mem_ack_i ? HALT : DRAIN;
          HALT:  r_state <= (start_i & ~r_err) ? RUN : HALT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench; a reference model predicts each cycle's outputs, a monitor compares them.
module tb_fetch_ctrl;
  localparam int TO = 15;
  logic clk = 0, rst = 0, start_i = 0, halt_i = 0, de_stall_i = 0, br_req_i = 0, mem_ack_i = 0;
  logic [15:0] br_addr_i = 0, fetch_addr_i = 0;
  logic mem_req_o, if_stall_o, if_branch_o, flush_o, err_o;
  logic [15:0] mem_addr_o, if_baddr_o;
  logic [1:0] state_o;
  fetch_ctrl #(.ADDR(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .halt_i(halt_i), .de_stall_i(de_stall_i),
    .br_req_i(br_req_i), .br_addr_i(br_addr_i), .fetch_addr_i(fetch_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .if_stall_o(if_stall_o), .if_branch_o(if_branch_o), .if_baddr_o(if_baddr_o),
    .flush_o(flush_o), .err_o(err_o), .state_o(state_o)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic req; logic [15:0] addr; logic stall; logic br; logic [15:0] baddr; logic fl; logic err; logic [1:0] st;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_wait = 0;
  bit m_pbv = 0, m_err = 0;
  logic [15:0] m_pba = 0;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("mem_req", 16'(mem_req_o), 16'(e.req));
      chk("mem_addr", mem_addr_o, e.addr);
      chk("if_stall", 16'(if_stall_o), 16'(e.stall));
      chk("if_branch", 16'(if_branch_o), 16'(e.br));
      chk("if_baddr", if_baddr_o, e.baddr);
      chk("flush", 16'(flush_o), 16'(e.fl));
      chk("err", 16'(err_o), 16'(e.err));
      chk("state", 16'(state_o), 16'(e.st));
    end
  end
  // drive one cycle, predict its outputs from the rules, then advance the model across the edge
  task automatic step(input bit rn, input bit st, input bit ht, input bit ds, input bit brq,
                      input logic [15:0] ba, input bit ack);
    exp_t e;
    bit run, busy, redir, adv, tmo;
    logic [15:0] fa;
    fa = 16'($urandom);
    rst = rn; start_i = st; halt_i = ht; de_stall_i = ds; br_req_i = brq; br_addr_i = ba;
    mem_ack_i = ack; fetch_addr_i = fa;
    run = m_st == 1;
    busy = m_st == 1 || m_st == 2;
    redir = run && ack && !ht && (m_pbv || brq);
    adv = run && ack && !ds && !ht;
    e.req = busy; e.addr = fa; e.stall = !(redir || adv); e.br = redir;
    e.baddr = redir ? (brq ? ba : m_pba) : 16'h0; e.fl = redir; e.err = m_err; e.st = 2'(m_st);
    q.push_back(e);
    if (!rn) begin
      m_st = 0; m_pbv = 0; m_pba = 0; m_wait = 0; m_err = 0;
    end else begin
      tmo = busy && !ack && (m_wait + 1 >= TO);
      m_wait = (busy && !ack) ? m_wait + 1 : 0;
      if (tmo) begin
        m_st = 3; m_err = 1; m_pbv = 0;
      end else if (m_st == 0) begin
        if (st) m_st = 1;
      end else if (m_st == 1) begin
        if (ht) begin m_pbv = 0; m_st = ack ? 3 : 2; end
        else if (redir) m_pbv = 0;
        else if (brq) begin m_pbv = 1; m_pba = ba; end
      end else if (m_st == 2) begin
        if (ack) m_st = 3;
      end else if (st && !m_err) m_st = 1;
      if (!(m_st == 1 || m_st == 2)) m_wait = 0;
    end
    @(posedge clk); #1;
  endtask
  initial begin
    int b;
    @(posedge clk); @(posedge clk); #1;
    step(0, 1, 0, 0, 1, 16'h1234, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 16'h0040, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 16'h0010, 0);
    step(1, 0, 0, 0, 1, 16'h0020, 0);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 16'h0077, 1);
    step(1, 0, 1, 0, 1, 16'h0055, 0);
    step(1, 0, 0, 0, 1, 16'h0066, 0);
    step(1, 0, 1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1, 16'h0099, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < TO + 1; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      b = (i % 400 < 20) ? 0 : int'($urandom_range(0, 3) != 0);
      step((m_err && $urandom_range(0, 19) == 0) || $urandom_range(0, 299) == 0 ? 0 : 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, 16'($urandom), b[0]);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
